fanout_frontend_np: RTL and testbench
=====================================

Name: fanout_frontend_np

Overview:
Parametrised N-path fan-out link-element front-end. It accepts a routed message on the forward token channel and stores/forwards NUM_IDS ID words. It rewrites the attribute word's path-length field, then captures up to NUM_PATH routing words into path slots that are requested to the back-end one by one. It generalises the 2-path front-end with configurable path count, ID count, length-field placement, outstanding-request tracking and slot-full back-pressure.

Parameters:
NUM_PATH, 2, number of path slots (>=2); slot index width = $clog2(NUM_PATH)
NUM_IDS, 3, ID words stored before the attribute word, including the acquire token word (>=2)
LEN_LSB, 8, LSB of the path-length field in the attribute word
LEN_W, 8, width of the path-length field

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
I_FTk  in  FTk_t  forward tokens from upstream
O_BTk  out  BTk_t  back-prop tokens to upstream
O_FTk  out  FTk_t  forward tokens to buffer (registered)
I_BTk  in  BTk_t  back-prop tokens from downstream
O_Req  out  1  path request to back-end
I_Ack  in  1  back-end consumed oldest pending path
I_Full_Buff  in  1  downstream buffer full
O_We_BUFF_ID  out  1  ID buffer write enable
O_We_BUFF  out  1  data buffer write enable
O_Unit_Length  out  1  route is unit length (field was zero)
O_PATH  out  NUM_PATH*WIDTH_DATA  path slots; slot k at [k*WIDTH_DATA +: WIDTH_DATA]
O_Rd_Idx  out  $clog2(NUM_PATH)  slot the back-end must read next
O_Pend  out  $clog2(NUM_PATH+1)  outstanding path count
is_Busy  in  1  back-end busy
O_NWe  out  1  inhibit buffer writes
I_InC  in  bit2_t  condition code in
O_InC  out  bit2_t  condition code out (combinational pass-through)

Behaviour:
- Clock/reset: single clock; synchronous active-high reset.
- Reset values: FSM=INIT; O_FTk='0; O_BTk follows the INIT pass-through; all flags, counters, indices and O_PATH = 0.
- Token decode (TokenDec): acq = acquire message/flag-msg; rls = release message/flag-msg.
- Forward output: O_FTk is I_FTk (or the rewritten word) registered once, so latency is 1 cycle. Dropped words give '0.
- FSM states: INIT, ST_ID, ATTR, RUN, TERM.
- INIT:
  - acq -> ST_ID; id_cnt=1; word forwarded.
  - Otherwise stay.
  - O_BTk = I_BTk, with n ORed with the local stall.
- ST_ID:
  - Each valid word is forwarded and increments id_cnt.
  - Valid with id_cnt==NUM_IDS-1 -> ATTR.
  - O_We_BUFF_ID=1 whenever id_cnt!=0.
  - id_cnt clears on entry to INIT.
- ATTR, on valid word, with L = d[LEN_LSB+:LEN_W]:
  - L!=0: forward with the field replaced by L-1 (other bits intact); long=1; O_We_BUFF=1 next cycle.
  - L==0: word dropped; O_Unit_Length=1 next cycle, held until the next valid word.
  - Transition: ~R_Full -> RUN. A registered release at O_FTk (v&a&r & ~R_Full) -> INIT, with priority.
- RUN:
  - Capture = valid & ~is_Busy & (O_Pend<NUM_PATH).
  - On capture: O_PATH[wr_idx] <= I_FTk.d; wr_idx = (wr_idx+1) mod NUM_PATH, wrapping NUM_PATH-1 -> 0; O_Pend+1.
  - Captured word is also forwarded only if long.
  - Valid word with O_Pend==NUM_PATH is not captured; O_BTk.n=1 that cycle.
  - Leave RUN: -> TERM on the last slot filled; -> INIT on registered release.
- TERM:
  - Stays until O_Pend==0 after I_Ack, or release -> INIT.
- Request/ack:
  - O_Req = capture | (O_Pend!=0), combinational.
  - I_Ack with O_Pend!=0: rd_idx advances mod NUM_PATH and O_Pend-1.
  - Capture and ack in the same cycle: O_Pend unchanged, both indices advance.
  - I_Ack with O_Pend==0 is ignored.
- O_BTk outside INIT:
  - n = R_Full | (O_Pend==NUM_PATH) | O_We_BUFF.
  - t/v/c from the registered I_BTk.
  - During ID capture the registered BTk is '0.
- R_Full: I_Full_Buff delayed 1 cycle.
- O_NWe:
  - Set on rls while is_Busy in INIT/ST_ID/ATTR.
  - Cleared when ~is_Busy or FSM in RUN/TERM.
- Reset mid-message: everything returns to reset values next cycle. Pending paths are discarded and no O_Req follows.

Test Plan:
- Acquire, 2 IDs, attr with L=3, 2 routing words, release, back-end idle, Ack 1 cycle after each Req -> O_FTk attr field=2; slots 0/1 hold the route data; O_Pend 1,0,1,0; FSM returns to INIT.
- Attr with L=0 -> attr not forwarded; O_Unit_Length=1 one cycle later; routing words captured but O_FTk='0 for them.
- NUM_PATH=4, no Ack, 5 routing words -> slots 0..3 filled; 5th word gives O_BTk.n=1 and is not captured; an Ack then frees slot 0 and O_Rd_Idx=1.
- Capture and I_Ack in the same cycle with O_Pend=1 -> O_Pend stays 1; wr_idx and rd_idx both increment; wrap at 3->0 checked.
- Release during ST_ID with is_Busy=1 -> O_NWe=1 next cycle; clears the cycle after is_Busy drops.
- Reset asserted in RUN with O_Pend=2 -> next cycle FSM=INIT, O_Pend=0, O_Req=0, O_PATH=0.

Source files
------------

// File: rtl/fanout_frontend_np.sv
// fanout_frontend_np: N-path fan-out front-end; forwards IDs, rewrites the path-length
// field and captures routing words into slots that are requested to the back-end in order.
package fanout_frontend_np_pkg;
    localparam int WIDTH_DATA = 32;
    typedef logic [1:0] bit2_t;
    typedef struct packed {
        logic v;
        logic a;
        logic r;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;
    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
endpackage

module fanout_frontend_np
    import fanout_frontend_np_pkg::*;
#(
    parameter int NUM_PATH = 2,
    parameter int NUM_IDS = 3,
    parameter int LEN_LSB = 8,
    parameter int LEN_W = 8,
    localparam int IW = $clog2(NUM_PATH),
    localparam int PW = $clog2(NUM_PATH + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  FTk_t                           I_FTk,
    output BTk_t                           O_BTk,
    output FTk_t                           O_FTk,
    input  BTk_t                           I_BTk,
    output logic                           O_Req,
    input  logic                           I_Ack,
    input  logic                           I_Full_Buff,
    output logic                           O_We_BUFF_ID,
    output logic                           O_We_BUFF,
    output logic                           O_Unit_Length,
    output logic [NUM_PATH*WIDTH_DATA-1:0] O_PATH,
    output logic [IW-1:0]                  O_Rd_Idx,
    output logic [PW-1:0]                  O_Pend,
    input  logic                           is_Busy,
    output logic                           O_NWe,
    input  bit2_t                          I_InC,
    output bit2_t                          O_InC
);
    localparam int CW = $clog2(NUM_IDS + 1);
    typedef enum logic [2:0] {INIT, ST_ID, ATTR, RUN, TERM} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] id_cnt, id_cnt_nxt;
    logic acq, rls, rls_out, cap, ack_ok, long_q, long_nxt, r_full, we_buff_nxt, unit_nxt;
    logic [LEN_W-1:0] len;
    logic [IW-1:0] wr_idx;
    logic [PW-1:0] pend_nxt;
    FTk_t ftk_nxt, attr_word;
    BTk_t btk_q;

    assign acq = I_FTk.v & I_FTk.a & ~I_FTk.r;
    assign rls = I_FTk.v & I_FTk.a & I_FTk.r;
    assign rls_out = O_FTk.v & O_FTk.a & O_FTk.r & ~r_full;
    assign len = I_FTk.d[LEN_LSB +: LEN_W];
    assign cap = (state == RUN) & I_FTk.v & ~rls & ~is_Busy & (O_Pend < PW'(NUM_PATH));
    assign ack_ok = I_Ack & (O_Pend != '0);
    assign pend_nxt = O_Pend + PW'(cap) - PW'(ack_ok);
    assign O_Req = cap | (O_Pend != '0);
    assign O_We_BUFF_ID = id_cnt != '0;
    assign O_InC = I_InC;

    always_comb begin
        attr_word = I_FTk;
        attr_word.d[LEN_LSB +: LEN_W] = len - LEN_W'(1);
    end

    // INIT passes upstream back-pressure straight through; elsewhere it is registered
    always_comb begin
        O_BTk = (state == INIT) ? I_BTk : btk_q;
        O_BTk.n = (state == INIT) ? (I_BTk.n | r_full)
                                  : (r_full | (O_Pend == PW'(NUM_PATH)) | O_We_BUFF);
    end

    always_comb begin
        state_nxt = state;
        id_cnt_nxt = id_cnt;
        ftk_nxt = '0;
        long_nxt = long_q;
        we_buff_nxt = 1'b0;
        unit_nxt = I_FTk.v ? 1'b0 : O_Unit_Length;
        case (state)
            INIT: if (acq) begin
                state_nxt = ST_ID;
                id_cnt_nxt = CW'(1);
                ftk_nxt = I_FTk;
            end
            ST_ID: if (I_FTk.v) begin
                ftk_nxt = I_FTk;
                id_cnt_nxt = id_cnt + CW'(1);
                state_nxt = (id_cnt == CW'(NUM_IDS - 1)) ? ATTR : ST_ID;
            end
            ATTR: if (I_FTk.v & ~r_full) begin
                state_nxt = RUN;
                long_nxt = len != '0;
                we_buff_nxt = len != '0;
                unit_nxt = len == '0;
                ftk_nxt = (len != '0) ? attr_word : '0;
            end
            RUN: begin
                ftk_nxt = ((cap & long_q) | rls) ? I_FTk : '0;
                state_nxt = (cap & (pend_nxt == PW'(NUM_PATH))) ? TERM : RUN;
            end
            TERM: begin
                ftk_nxt = rls ? I_FTk : '0;
                state_nxt = (pend_nxt == '0) ? INIT : TERM;
            end
            default: state_nxt = INIT;
        endcase
        if ((state inside {ATTR, RUN, TERM}) && rls_out) state_nxt = INIT;
        if (state_nxt == INIT && state != INIT) id_cnt_nxt = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
            id_cnt <= '0;
            O_FTk <= '0;
            long_q <= 1'b0;
            O_We_BUFF <= 1'b0;
            O_Unit_Length <= 1'b0;
            r_full <= 1'b0;
            btk_q <= '0;
            O_Pend <= '0;
            O_PATH <= '0;
            wr_idx <= '0;
            O_Rd_Idx <= '0;
            O_NWe <= 1'b0;
        end else begin
            state <= state_nxt;
            id_cnt <= id_cnt_nxt;
            O_FTk <= ftk_nxt;
            long_q <= long_nxt;
            O_We_BUFF <= we_buff_nxt;
            O_Unit_Length <= unit_nxt;
            r_full <= I_Full_Buff;
            btk_q <= (state == ST_ID) ? '0 : I_BTk;
            O_Pend <= pend_nxt;
            if (cap) begin
                O_PATH[int'(wr_idx)*WIDTH_DATA +: WIDTH_DATA] <= I_FTk.d;
                wr_idx <= (wr_idx == IW'(NUM_PATH - 1)) ? '0 : wr_idx + IW'(1);
            end
            if (ack_ok) O_Rd_Idx <= (O_Rd_Idx == IW'(NUM_PATH - 1)) ? '0 : O_Rd_Idx + IW'(1);
            O_NWe <= (rls & is_Busy & (state inside {INIT, ST_ID, ATTR})) ? 1'b1
                   : (~is_Busy | (state inside {RUN, TERM})) ? 1'b0 : O_NWe;
        end
    end
endmodule

// File: tb/tb_fanout_frontend_np.sv
// tb_fanout_frontend_np: directed message sequences with random payloads, checked against
// a counter/slot-array model of captures and acknowledges.
module tb_fanout_frontend_np;
    import fanout_frontend_np_pkg::*;
    localparam int NP = 4;
    localparam int DW = WIDTH_DATA;
    localparam int LSB = 8;
    localparam int PWD = NP * DW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    FTk_t I_FTk, O_FTk;
    BTk_t I_BTk, O_BTk;
    logic O_Req, I_Ack, I_Full_Buff, O_We_BUFF_ID, O_We_BUFF, O_Unit_Length, is_Busy, O_NWe;
    logic [PWD-1:0] O_PATH;
    logic [1:0] O_Rd_Idx;
    logic [2:0] O_Pend;
    bit2_t I_InC, O_InC;

    int tests = 0;
    int fails = 0;
    int caps = 0;
    int acks = 0;
    logic long_m = 1'b0;
    logic [DW-1:0] slots [NP];

    always #5 clock = ~clock;

    fanout_frontend_np #(.NUM_PATH(NP), .NUM_IDS(3), .LEN_LSB(LSB), .LEN_W(8)) dut (
        .clock(clock), .reset(reset), .I_FTk(I_FTk), .O_BTk(O_BTk), .O_FTk(O_FTk),
        .I_BTk(I_BTk), .O_Req(O_Req), .I_Ack(I_Ack), .I_Full_Buff(I_Full_Buff),
        .O_We_BUFF_ID(O_We_BUFF_ID), .O_We_BUFF(O_We_BUFF), .O_Unit_Length(O_Unit_Length),
        .O_PATH(O_PATH), .O_Rd_Idx(O_Rd_Idx), .O_Pend(O_Pend), .is_Busy(is_Busy),
        .O_NWe(O_NWe), .I_InC(I_InC), .O_InC(O_InC)
    );

    task automatic chk(input string tag, input logic [PWD-1:0] got, input logic [PWD-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic FTk_t mk(input logic v, input logic a, input logic r, input logic [DW-1:0] d);
        FTk_t f;
        f.v = v;
        f.a = a;
        f.r = r;
        f.d = d;
        return f;
    endfunction

    function automatic logic [PWD-1:0] exp_path();
        logic [PWD-1:0] p;
        p = '0;
        for (int k = 0; k < NP; k++) p[k*DW +: DW] = slots[k];
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input FTk_t f);
        I_FTk = f;
        tick();
        I_FTk = '0;
    endtask

    task automatic clear_model();
        caps = 0;
        acks = 0;
        for (int k = 0; k < NP; k++) slots[k] = '0;
    endtask

    task automatic header(input logic [7:0] len);
        FTk_t w;
        logic [DW-1:0] d;
        w = mk(1'b1, 1'b1, 1'b0, $urandom);
        send(w);
        chk("acq_fwd", O_FTk, w);
        chk("we_id", O_We_BUFF_ID, 1'b1);
        for (int i = 0; i < 2; i++) begin
            w = mk(1'b1, 1'b0, 1'b0, $urandom);
            send(w);
            chk("id_fwd", O_FTk, w);
        end
        d = $urandom;
        d[LSB +: 8] = len;
        send(mk(1'b1, 1'b0, 1'b0, d));
        if (len != 8'd0) begin
            chk("attr_fwd", O_FTk, mk(1'b1, 1'b0, 1'b0, d - (DW'(1) << LSB)));
            chk("we_buff", O_We_BUFF, 1'b1);
            chk("attr_n", O_BTk.n, 1'b1);
        end else begin
            chk("attr_drop", O_FTk, '0);
            chk("unit_len", O_Unit_Length, 1'b1);
            chk("we_buff0", O_We_BUFF, 1'b0);
        end
        long_m = len != 8'd0;
    endtask

    task automatic route(input logic v, input logic ack);
        logic [DW-1:0] d;
        int pend;
        logic cp, ak;
        FTk_t e;
        d = $urandom;
        pend = caps - acks;
        cp = v && pend < NP;
        ak = ack && pend != 0;
        I_FTk = mk(v, 1'b0, 1'b0, d);
        I_Ack = ack;
        #1;
        chk("req", O_Req, cp || pend != 0);
        if (v && !cp) chk("full_n", O_BTk.n, 1'b1);
        tick();
        I_FTk = '0;
        I_Ack = 1'b0;
        if (cp) begin
            slots[caps % NP] = d;
            caps++;
        end
        if (ak) acks++;
        e = '0;
        if (cp && long_m) e = mk(1'b1, 1'b0, 1'b0, d);
        chk("pend", O_Pend, PWD'(caps - acks));
        chk("rd_idx", O_Rd_Idx, PWD'(acks % NP));
        chk("path", O_PATH, exp_path());
        chk("ftk", O_FTk, e);
    endtask

    task automatic release_msg();
        FTk_t w;
        w = mk(1'b1, 1'b1, 1'b1, $urandom);
        send(w);
        chk("rls_fwd", O_FTk, w);
        tick();
    endtask

    initial begin
        BTk_t b, eb;
        int p;
        logic rv, ra;
        I_FTk = '0;
        I_BTk = '0;
        I_Ack = 1'b0;
        I_Full_Buff = 1'b0;
        is_Busy = 1'b0;
        I_InC = '0;
        clear_model();
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ftk", O_FTk, '0);
        chk("rst_pend", O_Pend, '0);
        chk("rst_req", O_Req, 1'b0);
        chk("rst_path", O_PATH, '0);
        chk("rst_rd", O_Rd_Idx, '0);
        chk("rst_nwe", O_NWe, 1'b0);
        chk("rst_unit", O_Unit_Length, 1'b0);
        chk("rst_weid", O_We_BUFF_ID, 1'b0);

        b = $urandom;
        b.n = 1'b0;
        I_BTk = b;
        I_InC = bit2_t'($urandom);
        #1;
        chk("init_btk", O_BTk, b);
        chk("inc", O_InC, I_InC);
        I_Full_Buff = 1'b1;
        tick();
        eb = b;
        eb.n = 1'b1;
        chk("full_btk", O_BTk, eb);
        I_Full_Buff = 1'b0;
        tick();
        chk("unfull_btk", O_BTk, b);
        I_BTk = '0;

        header(8'($urandom_range(1, 255)));
        route(1'b1, 1'b0);
        route(1'b0, 1'b1);
        route(1'b1, 1'b0);
        route(1'b0, 1'b1);
        release_msg();

        header(8'd0);
        route(1'b1, 1'b0);
        chk("unit_clr", O_Unit_Length, 1'b0);
        route(1'b0, 1'b1);
        release_msg();

        header(8'($urandom_range(1, 255)));
        route(1'b1, 1'b0);
        route(1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        chk("mid_rst_pend", O_Pend, '0);
        chk("mid_rst_req", O_Req, 1'b0);
        chk("mid_rst_path", O_PATH, '0);
        chk("mid_rst_ftk", O_FTk, '0);
        tick();
        chk("mid_rst_req2", O_Req, 1'b0);

        header(8'($urandom_range(1, 255)));
        repeat (5) route(1'b1, 1'b0);
        repeat (4) route(1'b0, 1'b1);

        header(8'($urandom_range(1, 255)));
        route(1'b1, 1'b0);
        repeat (5) route(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            p = caps - acks;
            ra = 1'($urandom);
            rv = 1'($urandom);
            if (p == NP - 1 && !ra) rv = 1'b0;
            route(rv, ra);
        end
        for (int i = 0; i < NP && caps != acks; i++) route(1'b0, 1'b1);
        release_msg();

        send(mk(1'b1, 1'b1, 1'b0, $urandom));
        is_Busy = 1'b1;
        send(mk(1'b1, 1'b1, 1'b1, $urandom));
        chk("nwe_set", O_NWe, 1'b1);
        chk("id_btk", O_BTk, '0);
        tick();
        chk("nwe_hold", O_NWe, 1'b1);
        is_Busy = 1'b0;
        tick();
        chk("nwe_clr", O_NWe, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("end_weid", O_We_BUFF_ID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
